// File: rtl/game_ctrl.sv
// Two-player game sequencer: start screen, serve delay, rally scoring and a
// game-over screen with a start-button lockout. Every output is registered.
module game_ctrl #(
    parameter int unsigned WIN_SCORE       = 5,
    parameter int unsigned SERVE_TICKS     = 120,
    parameter int unsigned OVER_LOCK_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       tick,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [1:0] state,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       ball_en,
    output logic       ball_reset,
    output logic       winner
);

    localparam int unsigned MAX_TICKS =
        (SERVE_TICKS > OVER_LOCK_TICKS) ? SERVE_TICKS : OVER_LOCK_TICKS;
    localparam int unsigned CNT_W = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] OVER_LOCK  = CNT_W'(OVER_LOCK_TICKS);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } fsm_t;

    fsm_t             fsm_r;
    fsm_t             fsm_s;
    logic             start_q_r;
    logic             start_edge_s;
    logic [3:0]       score_p1_r;
    logic [3:0]       score_p1_s;
    logic [3:0]       score_p2_r;
    logic [3:0]       score_p2_s;
    logic             winner_r;
    logic             winner_s;
    logic [CNT_W-1:0] tick_cnt_r;
    logic [CNT_W-1:0] tick_cnt_s;
    logic [CNT_W-1:0] cnt_upd_s;

    // Display code: SERVE and PLAY both show as "in game".
    function automatic logic [1:0] encode_state(input fsm_t s);
        case (s)
            ST_START: encode_state = 2'b00;
            ST_SERVE: encode_state = 2'b01;
            ST_PLAY:  encode_state = 2'b01;
            ST_OVER:  encode_state = 2'b10;
            default:  encode_state = 2'b00;
        endcase
    endfunction

    assign start_edge_s = start_btn & ~start_q_r;

    // Next-state, score, winner and tick-counter logic.
    always_comb begin
        fsm_s      = fsm_r;
        score_p1_s = score_p1_r;
        score_p2_s = score_p2_r;
        winner_s   = winner_r;
        cnt_upd_s  = tick_cnt_r;
        case (fsm_r)
            ST_START: begin
                if (start_edge_s) begin
                    score_p1_s = 4'd0;
                    score_p2_s = 4'd0;
                    fsm_s      = ST_SERVE;
                end else begin
                    fsm_s = ST_START;
                end
            end
            ST_SERVE: begin
                if (tick && (tick_cnt_r == SERVE_LAST)) begin
                    fsm_s = ST_PLAY;
                end else if (tick) begin
                    cnt_upd_s = tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_upd_s = tick_cnt_r;
                end
            end
            ST_PLAY: begin
                // A double miss is treated as a void rally: nobody scores.
                if (miss_p1 && miss_p2) begin
                    fsm_s = ST_SERVE;
                end else if (miss_p1) begin
                    score_p2_s = score_p2_r + 4'd1;
                    if (score_p2_s == WIN) begin
                        fsm_s    = ST_OVER;
                        winner_s = 1'b1;
                    end else begin
                        fsm_s = ST_SERVE;
                    end
                end else if (miss_p2) begin
                    score_p1_s = score_p1_r + 4'd1;
                    if (score_p1_s == WIN) begin
                        fsm_s    = ST_OVER;
                        winner_s = 1'b0;
                    end else begin
                        fsm_s = ST_SERVE;
                    end
                end else begin
                    fsm_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_edge_s && (tick_cnt_r >= OVER_LOCK)) begin
                    fsm_s = ST_START;
                end else if (tick && (tick_cnt_r < OVER_LOCK)) begin
                    cnt_upd_s = tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_upd_s = tick_cnt_r;
                end
            end
            default: begin
                fsm_s = ST_START;
            end
        endcase
        // Any state change restarts the count, which also drops a coincident tick.
        tick_cnt_s = (fsm_s != fsm_r) ? {CNT_W{1'b0}} : cnt_upd_s;
    end

    // State, score and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r      <= ST_START;
            start_q_r  <= 1'b1;
            score_p1_r <= 4'd0;
            score_p2_r <= 4'd0;
            winner_r   <= 1'b0;
            tick_cnt_r <= {CNT_W{1'b0}};
        end else begin
            fsm_r      <= fsm_s;
            start_q_r  <= start_btn;
            score_p1_r <= score_p1_s;
            score_p2_r <= score_p2_s;
            winner_r   <= winner_s;
            tick_cnt_r <= tick_cnt_s;
        end
    end

    // Output registers, loaded from next-state values so a change is visible right after its edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= 2'b00;
            dig1       <= 4'd0;
            dig0       <= 4'd0;
            ball_en    <= 1'b0;
            ball_reset <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= encode_state(fsm_s);
            dig1       <= (fsm_s == ST_OVER) ? 4'h0 : score_p1_s;
            dig0       <= (fsm_s == ST_OVER) ? (winner_s ? 4'hB : 4'hA) : score_p2_s;
            ball_en    <= (fsm_s == ST_PLAY);
            ball_reset <= (fsm_s == ST_SERVE) && (fsm_r != ST_SERVE);
            winner     <= winner_s;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed scoreboard bench for game_ctrl: expectations are queued as each
// stimulus step is driven and compared one edge later.
module tb_game_ctrl;

    localparam int SERVE_N = 120;
    localparam int LOCK_N  = 60;
    localparam int WIN_N   = 5;

    logic       clk = 1'b0;
    logic       reset, start_btn, tick, miss_p1, miss_p2;
    logic [1:0] state;
    logic [3:0] dig1, dig0;
    logic       ball_en, ball_reset, winner;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .tick(tick),
        .miss_p1(miss_p1), .miss_p2(miss_p2), .state(state), .dig1(dig1),
        .dig0(dig0), .ball_en(ball_en), .ball_reset(ball_reset), .winner(winner)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       ben;
        logic       brst;
        logic       win;
        logic       win_care;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   p1 = 0;
    int   p2 = 0;

    task automatic step(input logic rst, input logic sb, input logic tk,
                        input logic m1, input logic m2, input string tag,
                        input logic [1:0] st, input logic [3:0] d1, input logic [3:0] d0,
                        input logic ben, input logic brst, input logic win, input logic wc);
        exp_t e;
        exp_t got;
        logic [12:0] obs;
        logic [12:0] req;
        reset = rst; start_btn = sb; tick = tk; miss_p1 = m1; miss_p2 = m2;
        e.tag = tag; e.st = st; e.d1 = d1; e.d0 = d0;
        e.ben = ben; e.brst = brst; e.win = win; e.win_care = wc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        obs = {state, dig1, dig0, ball_en, ball_reset, (got.win_care ? winner : got.win)};
        req = {got.st, got.d1, got.d0, got.ben, got.brst, got.win};
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed st=%b d1=%h d0=%h en=%b rst=%b win=%b, expected st=%b d1=%h d0=%h en=%b rst=%b win=%b",
                   got.tag, obs[12:11], obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
                   req[12:11], req[10:7], req[6:3], req[2], req[1], req[0]);
        end
    endtask

    // Serve countdown: ball_en rises only on the SERVE_N-th tick.
    task automatic serve_ticks(input string tag, input logic sb);
        for (int i = 0; i < SERVE_N; i++)
            step(1'b0, sb, 1'b1, 1'b0, 1'b0, tag, 2'b01, 4'(p1), 4'(p2),
                 (i == SERVE_N - 1), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and start screen
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset0", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "reset1", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle",   2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start and serve
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start",  2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "brst_1cyc", 2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        serve_ticks("serve1", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "play_hold", 2'b01, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Player 1 scores, then a miss during SERVE is ignored
        p1 = 1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "p1_score", 2'b01, 4'(p1), 4'(p2), 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "miss_in_serve", 2'b01, 4'(p1), 4'(p2), 1'b0, 1'b0, 1'b0, 1'b0);
        serve_ticks("serve2", 1'b0);

        // Simultaneous miss voids the rally
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "double_miss", 2'b01, 4'(p1), 4'(p2), 1'b0, 1'b1, 1'b0, 1'b0);
        serve_ticks("serve3", 1'b0);

        // Player 2 runs out the game
        for (int k = 1; k <= WIN_N; k++) begin
            p2 = k;
            if (k == WIN_N) begin
                step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "p2_wins", 2'b10, 4'h0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "p2_score", 2'b01, 4'(p1), 4'(p2), 1'b0, 1'b1, 1'b0, 1'b0);
                serve_ticks("serve_p2", 1'b0);
            end
        end

        // Over lockout: first 30 ticks, a rejected start, then the rest
        for (int i = 0; i < LOCK_N / 2; i++)
            step(1'b0, 1'b0, 1'b1, (i == 3), 1'b0, "over_lock", 2'b10, 4'h0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start_locked", 2'b10, 4'h0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < LOCK_N / 2; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "over_lock2", 2'b10, 4'h0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "over_exit", 2'b00, 4'(p1), 4'(p2), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "start_idle", 2'b00, 4'(p1), 4'(p2), 1'b0, 1'b0, 1'b0, 1'b0);

        // New game; the tick on the starting edge must not count toward the serve delay
        p1 = 0; p2 = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "restart", 2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        serve_ticks("serve4", 1'b1);

        // Reset mid-play with the button held and a miss pending
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "reset_play", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "held_btn0", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "held_btn1", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "btn_fall", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "btn_rise", 2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5, points to win a game; legal range 1-9.
REQ-002 Parameter SERVE_TICKS, default 120, number of frame ticks the block waits in SERVE before play starts.
REQ-003 Parameter OVER_LOCK_TICKS, default 60, number of frame ticks in OVER during which start_btn is ignored.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_btn  input  1  debounced start button, level.
REQ-007 tick  input  1  one-cycle frame-refresh pulse, at most one per frame.
REQ-008 miss_p1  input  1  one-cycle pulse: ball passed player 1's paddle, so player 2 scores.
REQ-009 miss_p2  input  1  one-cycle pulse: ball passed player 2's paddle, so player 1 scores.
REQ-010 state  output  2  display state: 00 = start screen, 01 = in game, 10 = game over.
REQ-011 dig1  output  4  left display digit.
REQ-012 dig0  output  4  right display digit.
REQ-013 ball_en  output  1  ball motion enable.
REQ-014 ball_reset  output  1  one-cycle pulse that recentres the ball.
REQ-015 winner  output  1  0 = player 1 won, 1 = player 2 won; meaningful only in OVER.

Function
REQ-016 Internal FSM states SHALL be START, SERVE, PLAY and OVER.
REQ-017 state SHALL encode START = 00, SERVE = 01, PLAY = 01, OVER = 10; 11 SHALL never be driven.
REQ-018 All outputs SHALL be registered.
REQ-019 A transition caused by a condition sampled at clock edge k SHALL be visible on the outputs after edge k.
REQ-020 start_edge SHALL be start_btn AND NOT start_q, where start_q is start_btn registered.
REQ-021 START: on start_edge, clear both scores, go to SERVE and pulse ball_reset.
REQ-022 SERVE: count tick pulses; on the SERVE_TICKS-th tick, go to PLAY and clear the counter.
REQ-023 PLAY: miss_p1 alone SHALL increment score_p2; miss_p2 alone SHALL increment score_p1.
REQ-024 After a PLAY score, if the new score equals WIN_SCORE, go to OVER and latch winner; otherwise go to SERVE and pulse ball_reset.
REQ-025 miss_p1 and miss_p2 high in the same cycle SHALL score nothing, and the FSM SHALL go to SERVE with a ball_reset pulse.
REQ-026 miss_p1 and miss_p2 SHALL be ignored in START, SERVE and OVER.
REQ-027 Only one score SHALL be taken per PLAY entry.
REQ-028 OVER: count tick pulses up to OVER_LOCK_TICKS; start_edge SHALL be ignored until that count is reached.
REQ-029 OVER: after the lockout, start_edge SHALL go to START and clear the counter.
REQ-030 ball_en SHALL be 1 only while in PLAY.
REQ-031 ball_reset SHALL be high for exactly one cycle on each SERVE entry and low otherwise.
REQ-032 Scores SHALL be 4-bit binary in the range 0..WIN_SCORE and SHALL never exceed WIN_SCORE.
REQ-033 In START, SERVE and PLAY, dig1 SHALL equal score_p1 and dig0 SHALL equal score_p2.
REQ-034 In OVER, dig1 SHALL be 0 and dig0 SHALL be 4'hA if player 1 won, 4'hB if player 2 won.
REQ-035 The tick counter SHALL be wide enough for max(SERVE_TICKS, OVER_LOCK_TICKS) and SHALL never wrap.
REQ-036 The tick counter SHALL clear on every state change.
REQ-037 tick arriving in the same cycle as a transition SHALL NOT be counted toward the new state.

Reset
REQ-038 On reset, state SHALL be START (00).
REQ-039 On reset, both scores, dig1, dig0, winner, ball_en, ball_reset and the tick counter SHALL be 0.
REQ-040 On reset, start_q SHALL be set to 1, so a button held through reset does not start a game.
REQ-041 Reset asserted mid-game, in any state, SHALL take effect at the next edge with the values of REQ-038 to REQ-040, overriding all other inputs.

Verification
REQ-042 Start and serve: reset, start_btn rises -> after the next edge state = 01, ball_reset = 1 for one cycle, ball_en = 0; after 120 ticks -> ball_en = 1.
REQ-043 Single score: in PLAY, miss_p2 pulse -> dig1 = 1, dig0 = 0, ball_en = 0, ball_reset pulses; PLAY resumes after 120 ticks.
REQ-044 Player 2 wins: player 2 scores five times -> state = 10, winner = 1, dig1 = 0, dig0 = 4'hB.
REQ-045 Simultaneous miss: in PLAY, miss_p1 and miss_p2 both high -> scores unchanged, state stays 01, ball_reset pulses.
REQ-046 Over lockout: in OVER, start_edge at tick 30 -> state stays 10; start_edge after 60 ticks -> state = 00.
REQ-047 Reset mid-game: start_btn held high and reset asserted in PLAY -> all outputs 0, state 00, and no game starts until start_btn falls and rises again.
